pad_event_drain: RTL and testbench
==================================

// Module: pad_event_drain
// PURPOSE
//  Reader side of the sticky pad-hit accumulator. Consumes the 12-bit sticky hit vector, serialises
//  each set bit into one pad-index event on a valid/ready stream, and returns a one-hot clear pulse
//  so the writer can drop that bit. Sits between the pad accumulator and the sound/LED sequencer.
// PARAMETERS
//  N_PADS  12  width of hit vector / number of pads
//  IDX_W   4   event index width, >= clog2(N_PADS)
// PORTS
//  CLK          in   1       system clock, rising edge
//  RST          in   1       asynchronous, active-low reset
//  hit_vec      in   N_PADS  sticky hit bits from accumulator (1 = pad hit, not yet drained)
//  clr_mask     out  N_PADS  one-hot clear request to accumulator, 1-cycle pulse
//  ev_valid     out  1       event available
//  ev_ready     in   1       consumer accepts event
//  ev_idx       out  IDX_W   pad index of presented event
//  pending_cnt  out  IDX_W   registered popcount of hit_vec & ~clr_hold
//  ev_ts        out  16      event timestamp (only with EV_TIMESTAMP_EN)
// BEHAVIOUR
//  - Reset (RST=0, async): state=IDLE, ev_valid=0, ev_idx=0, clr_mask=0, clr_hold=0,
//    pending_cnt=0, last_ptr=N_PADS-1, ev_ts=0. Reset mid-event drops the event; no clear is issued.
//  - pending = hit_vec & ~clr_hold; clr_hold = clr_mask registered one cycle (masks the bit whose
//    clear has not yet landed in the accumulator).
//  - FSM: IDLE -> SCAN when |pending. SCAN: round-robin pick from pending, search starting at
//    (last_ptr+1) mod N_PADS, wrap N_PADS-1 -> 0; register pick into ev_idx, go PRESENT.
//    If pending==0 in SCAN, return to IDLE, ev_valid stays 0.
//  - PRESENT: ev_valid=1; ev_idx (and ev_ts) held stable until ev_valid&&ev_ready. On handshake:
//    ev_valid=0 next cycle, clr_mask=1<<ev_idx for exactly that cycle, last_ptr=ev_idx, go CLEAR.
//  - CLEAR: clr_mask=0, -> IDLE. The cleared bit is masked by clr_hold this cycle.
//  - Once presented, the event is delivered even if its hit_vec bit falls meanwhile.
//  - Latency: bit visible in IDLE at cycle t -> ev_valid=1 at t+2. Throughput with ev_ready=1:
//    one event / 4 cycles. ev_ready ignored outside PRESENT.
//  - pending_cnt updated every cycle, saturates at N_PADS (never wraps).
//  - A bit that re-sets after clearing is a new event; no coalescing beyond the sticky vector.
// CONFIGURATION
//  EV_TIMESTAMP_EN defined: 16-bit free-running cycle counter (0 at reset, wraps 0xFFFF->0x0000);
//    value captured into ev_ts on SCAN->PRESENT, held with ev_idx.
//  Not defined: counter and ev_ts port absent; all other behaviour identical.
// STRUCTURE
//  Shared package pad_pkg: N_PADS, IDX_W, state enum {IDLE,SCAN,PRESENT,CLEAR}, TS_W=16.
//  One sub-module: rr_priority_pick (pending vector + start pointer -> found flag + index, comb).
// TESTING
//  1 hit_vec=0x000 after reset -> ev_valid stays 0, clr_mask=0, pending_cnt=0 for 20 cycles.
//  2 hit_vec=0x010, ev_ready=1 -> ev_valid at t+2 with ev_idx=4; clr_mask=0x010 one cycle; bench
//    clears bit; no second event.
//  3 hit_vec=0x801 (sticky, cleared by bench model), last_ptr=11 after reset -> events idx 0 then 11.
//  4 hit_vec=0xFFF, ev_ready=1 -> 12 events idx 0..11 in order, pending_cnt 12 -> 0.
//  5 ev_ready=0 for 10 cycles in PRESENT, idx 7 -> ev_idx/ev_valid stable, no clr_mask until ready.
//  6 Assert RST in PRESENT -> ev_valid=0 immediately, clr_mask=0; after release, re-serves pending bit.

Source files
------------

// File: rtl/pad_pkg.sv
// rtl/pad_pkg.sv - shared constants, FSM state type and popcount helper for pad_event_drain
package pad_pkg;
    localparam int N_PADS = 12;
    localparam int IDX_W  = 4;
    localparam int TS_W   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        PRESENT = 2'd2,
        CLEAR   = 2'd3
    } state_e;

    // Popcount clamped to N_PADS so the count can never wrap in IDX_W bits.
    function automatic logic [IDX_W-1:0] sat_popcount(input logic [N_PADS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < N_PADS; i++) begin
            n += int'(v[i]);
        end
        if (n > N_PADS) begin
            n = N_PADS;
        end
        return IDX_W'(n);
    endfunction
endpackage

// File: rtl/pad_event_drain_if.sv
// rtl/pad_event_drain_if.sv - pad-index event stream; carries ev_ts only when EV_TIMESTAMP_EN is defined
interface pad_event_drain_if;
    import pad_pkg::*;

    logic             ev_valid;
    logic             ev_ready;
    logic [IDX_W-1:0] ev_idx;
`ifdef EV_TIMESTAMP_EN
    logic [TS_W-1:0]  ev_ts;

    modport master (output ev_valid, output ev_idx, output ev_ts, input ev_ready);
    modport slave  (input ev_valid, input ev_idx, input ev_ts, output ev_ready);
`else
    modport master (output ev_valid, output ev_idx, input ev_ready);
    modport slave  (input ev_valid, input ev_idx, output ev_ready);
`endif
endinterface

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin pick of the first set bit at or after start_i
module rr_priority_pick
    import pad_pkg::*;
(
    input  logic [N_PADS-1:0] pending_i,
    input  logic [IDX_W-1:0]  start_i,
    output logic              found_o,
    output logic [IDX_W-1:0]  idx_o
);
    localparam int SW = IDX_W + 1;

    logic [SW-1:0]    sum;
    logic [IDX_W-1:0] pos;

    // Walk offsets from far to near so the nearest set bit is the last one written.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        sum     = '0;
        pos     = '0;
        for (int k = N_PADS - 1; k >= 0; k--) begin
            sum = {1'b0, start_i} + SW'(k);
            if (sum >= SW'(N_PADS)) begin
                sum = sum - SW'(N_PADS);
            end
            pos = sum[IDX_W-1:0];
            if (pending_i[pos]) begin
                found_o = 1'b1;
                idx_o   = pos;
            end
        end
    end
endmodule

// File: rtl/pad_event_drain.sv
// rtl/pad_event_drain.sv - drains sticky pad-hit bits into one-at-a-time index events with clear pulses
// Optional: EV_TIMESTAMP_EN adds a free-running cycle counter captured into ev_ts per event.
module pad_event_drain
    import pad_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_PADS-1:0]   hit_vec_i,
    output logic [N_PADS-1:0]   clr_mask_o,
    output logic [IDX_W-1:0]    pending_cnt_o,
    pad_event_drain_if.master   ev_o
);
    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ev_idx_q, ev_idx_d;
    logic [IDX_W-1:0]  last_ptr_q, last_ptr_d;
    logic [N_PADS-1:0] clr_mask_q, clr_mask_d;
    logic [N_PADS-1:0] clr_hold_q;
    logic [IDX_W-1:0]  pending_cnt_q;

    logic [N_PADS-1:0] pending;
    logic [IDX_W-1:0]  start_ptr;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;

    // A clear still in flight to the accumulator must not be served again.
    assign pending   = hit_vec_i & ~clr_hold_q;
    assign start_ptr = (last_ptr_q == IDX_W'(N_PADS - 1)) ? '0 : last_ptr_q + IDX_W'(1);

    rr_priority_pick u_pick (
        .pending_i (pending),
        .start_i   (start_ptr),
        .found_o   (pick_found),
        .idx_o     (pick_idx)
    );

`ifdef EV_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q;
    logic [TS_W-1:0] ev_ts_q, ev_ts_d;
`endif

    always_comb begin
        state_d    = state_q;
        ev_idx_d   = ev_idx_q;
        last_ptr_d = last_ptr_q;
        clr_mask_d = '0;
`ifdef EV_TIMESTAMP_EN
        ev_ts_d    = ev_ts_q;
`endif
        case (state_q)
            IDLE: begin
                if (|pending) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (pick_found) begin
                    ev_idx_d = pick_idx;
`ifdef EV_TIMESTAMP_EN
                    ev_ts_d  = ts_cnt_q;
`endif
                    state_d  = PRESENT;
                end else begin
                    state_d  = IDLE;
                end
            end
            PRESENT: begin
                if (ev_o.ev_ready) begin
                    clr_mask_d = N_PADS'(1) << ev_idx_q;
                    last_ptr_d = ev_idx_q;
                    state_d    = CLEAR;
                end
            end
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            ev_idx_q      <= '0;
            last_ptr_q    <= IDX_W'(N_PADS - 1);
            clr_mask_q    <= '0;
            clr_hold_q    <= '0;
            pending_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            ev_idx_q      <= ev_idx_d;
            last_ptr_q    <= last_ptr_d;
            clr_mask_q    <= clr_mask_d;
            clr_hold_q    <= clr_mask_q;
            pending_cnt_q <= sat_popcount(pending);
        end
    end

`ifdef EV_TIMESTAMP_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_cnt_q <= '0;
            ev_ts_q  <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + TS_W'(1);
            ev_ts_q  <= ev_ts_d;
        end
    end

    assign ev_o.ev_ts = ev_ts_q;
`endif

    assign ev_o.ev_valid = (state_q == PRESENT);
    assign ev_o.ev_idx   = ev_idx_q;
    assign clr_mask_o    = clr_mask_q;
    assign pending_cnt_o = pending_cnt_q;
endmodule

// File: tb/tb_pad_event_drain.sv
// tb/tb_pad_event_drain.sv - randomized and directed bench for pad_event_drain against an event-level model
module tb_pad_event_drain;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] hit_vec = '0;
    logic [11:0] clr_mask;
    logic [3:0]  pending_cnt;

    pad_event_drain_if ev_if ();

    pad_event_drain dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .hit_vec_i     (hit_vec),
        .clr_mask_o    (clr_mask),
        .pending_cnt_o (pending_cnt),
        .ev_o          (ev_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: sticky vector drained round-robin, one event every four cycles at best.
    bit          m_valid, m_scan, m_cool;
    int          m_idx, m_last, m_cnt;
    logic [11:0] m_clr, m_hold;
    logic [15:0] m_ts, m_tsc;

    logic [11:0] clr_prev;
    int          clr_pulses;
    int          got_q[$];
    int          exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_next(input logic [11:0] p, input int last);
        for (int k = 1; k <= 12; k++) begin
            int i = (last + k) % 12;
            if (p[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_scan = 0; m_cool = 0;
        m_idx = 0; m_last = 11; m_cnt = 0;
        m_clr = '0; m_hold = '0; m_ts = '0; m_tsc = '0;
    endtask

    task automatic model_step(input logic [11:0] hv, input logic rdy);
        logic [11:0] pend;
        logic [11:0] n_clr;
        pend  = hv & ~m_hold;
        n_clr = '0;
        if (m_valid) begin
            if (rdy) begin
                n_clr   = 12'(1) << m_idx;
                m_last  = m_idx;
                m_valid = 0;
                m_cool  = 1;
            end
        end else if (m_cool) begin
            m_cool = 0;
        end else if (m_scan) begin
            m_scan = 0;
            if (pend != 0) begin
                m_idx   = rr_next(pend, m_last);
                m_valid = 1;
                m_ts    = m_tsc;
            end
        end else if (pend != 0) begin
            m_scan = 1;
        end
        m_cnt  = ($countones(pend) > 12) ? 12 : $countones(pend);
        m_hold = m_clr;
        m_clr  = n_clr;
        m_tsc  = m_tsc + 16'd1;
    endtask

    task automatic check_outputs();
        check_eq("ev_valid", 32'(ev_if.ev_valid), 32'(m_valid));
        if (m_valid) check_eq("ev_idx", 32'(ev_if.ev_idx), 32'(m_idx));
        check_eq("clr_mask", 32'(clr_mask), 32'(m_clr));
        check_eq("pending_cnt", 32'(pending_cnt), 32'(m_cnt));
`ifdef EV_TIMESTAMP_EN
        if (m_valid) check_eq("ev_ts", 32'(ev_if.ev_ts), 32'(m_ts));
`endif
    endtask

    // Called #1 after a clock edge; the accumulator applies a clear one edge after it is requested.
    task automatic cycle(input logic rdy, input logic [11:0] nh);
        ev_if.ev_ready = rdy;
        if (ev_if.ev_valid && rdy) got_q.push_back(int'(ev_if.ev_idx));
        @(posedge clk);
        model_step(hit_vec, rdy);
        #1;
        hit_vec  = (hit_vec & ~clr_prev) | nh;
        clr_prev = clr_mask;
        if (clr_mask != 0) clr_pulses++;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", 32'(ev_if.ev_valid), 32'd0);
        check_eq("rst_idx", 32'(ev_if.ev_idx), 32'd0);
        check_eq("rst_clr", 32'(clr_mask), 32'd0);
        check_eq("rst_cnt", 32'(pending_cnt), 32'd0);
`ifdef EV_TIMESTAMP_EN
        check_eq("rst_ts", 32'(ev_if.ev_ts), 32'd0);
`endif
        model_reset();
        clr_prev   = '0;
        clr_pulses = 0;
        got_q      = {};
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_events(input string tag);
        check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check_eq(tag, 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        int max_cnt;
        ev_if.ev_ready = 1'b0;
        #1;
        do_reset();

        // Idle with nothing pending
        for (int i = 0; i < 20; i++) cycle(1'($urandom_range(0, 1)), 12'h000);
        check_eq("t1_no_clr", 32'(clr_pulses), 32'd0);

        // Single hit on pad 4
        cycle(1'b1, 12'h010);
        for (int i = 0; i < 10; i++) cycle(1'b1, 12'h000);
        exp_q = {}; exp_q.push_back(4);
        check_events("t2_events");
        check_eq("t2_clr_pulses", 32'(clr_pulses), 32'd1);

        // Round-robin from last_ptr=11: pad 0 first, then 11
        do_reset();
        cycle(1'b1, 12'h801);
        for (int i = 0; i < 14; i++) cycle(1'b1, 12'h000);
        exp_q = {}; exp_q.push_back(0); exp_q.push_back(11);
        check_events("t3_events");

        // All pads hit
        do_reset();
        max_cnt = 0;
        cycle(1'b1, 12'hFFF);
        for (int i = 0; i < 60; i++) begin
            cycle(1'b1, 12'h000);
            if (int'(pending_cnt) > max_cnt) max_cnt = int'(pending_cnt);
        end
        exp_q = {};
        for (int i = 0; i < 12; i++) exp_q.push_back(i);
        check_events("t4_events");
        check_eq("t4_cnt_max", 32'(max_cnt), 32'd12);
        check_eq("t4_cnt_end", 32'(pending_cnt), 32'd0);

        // Back-pressure while presenting pad 7
        do_reset();
        cycle(1'b0, 12'h080);
        for (int i = 0; i < 13; i++) cycle(1'b0, 12'h000);
        check_eq("t5_hold_valid", 32'(ev_if.ev_valid), 32'd1);
        check_eq("t5_hold_idx", 32'(ev_if.ev_idx), 32'd7);
        check_eq("t5_no_clr", 32'(clr_pulses), 32'd0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 12'h000);
        exp_q = {}; exp_q.push_back(7);
        check_events("t5_events");
        check_eq("t5_clr_pulses", 32'(clr_pulses), 32'd1);

        // Reset while presenting; the still-set bit is served again afterwards
        do_reset();
        cycle(1'b0, 12'h080);
        for (int i = 0; i < 10 && !m_valid; i++) cycle(1'b0, 12'h000);
        check_eq("t6_presenting", 32'(ev_if.ev_valid), 32'd1);
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 12'h000);
        exp_q = {}; exp_q.push_back(7);
        check_events("t6_events");

        // Random hits and back-pressure, then drain
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [11:0] nh;
            nh = ($urandom_range(0, 3) == 0) ? (12'(1) << $urandom_range(0, 11)) : 12'h000;
            cycle(1'($urandom_range(0, 3) != 0), nh);
        end
        for (int i = 0; i < 80; i++) cycle(1'b1, 12'h000);
        check_eq("rand_drained", 32'(hit_vec), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
